count_monitor: RTL and testbench

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_monitor.sv | 178 +++++++++++++++++
 tb/tb_count_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// Count-stream monitor: compare-match with hold-off window, wrap detection and
// optional jump detection (compiled in when COUNT_MONITOR_JUMP_DET_EN is defined).
module count_monitor #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] count_in,
    input  logic       cfg_wr,
    input  logic [7:0] cfg_data,
    input  logic       irq_clr,
    output logic       match_pulse,
    output logic       wrap_pulse,
    output logic       jump_pulse,
    output logic       irq,
    output logic [7:0] hits,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] hold_cnt_r;
    logic [3:0] hold_cnt_nxt_s;
    logic [7:0] cmp_r;
    logic [7:0] prev_r;
    logic       prev_valid_r;
    logic       match_s;
    logic       wrap_s;
    logic       match_pulse_r;
    logic       wrap_pulse_r;
    logic       irq_r;
    logic [7:0] hits_r;

    function automatic logic is_wrap(input logic [7:0] prev_v, input logic [7:0] cur_v);
        return (prev_v == 8'hFF) && (cur_v == 8'h00);
    endfunction

    // Next-state, hold counter and match decision; match uses the cmp held before any write this cycle
    always_comb begin
        state_nxt_s    = state_r;
        hold_cnt_nxt_s = hold_cnt_r;
        match_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_wr) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (count_in == cmp_r) begin
                    match_s        = 1'b1;
                    state_nxt_s    = ST_HOLD;
                    hold_cnt_nxt_s = HOLD_LOAD;
                end else begin
                    state_nxt_s    = ST_ARMED;
                end
            end
            ST_HOLD: begin
                // Leaving on the step that reaches zero makes the window exactly HOLD_CYCLES samples
                if (hold_cnt_r <= 4'd1) begin
                    hold_cnt_nxt_s = 4'd0;
                    state_nxt_s    = ST_ARMED;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r - 4'd1;
                    state_nxt_s    = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                hold_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    // Wrap decision on the current sample against the previous one
    always_comb begin
        if (prev_valid_r) begin
            wrap_s = is_wrap(prev_r, count_in);
        end else begin
            wrap_s = 1'b0;
        end
    end

    // FSM state and hold counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
        end
    end

    // Compare register and previous-sample history
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_r        <= 8'h00;
            prev_r       <= 8'h00;
            prev_valid_r <= 1'b0;
        end else begin
            if (cfg_wr) begin
                cmp_r <= cfg_data;
            end
            prev_r       <= count_in;
            prev_valid_r <= 1'b1;
        end
    end

    // Registered pulses, sticky irq (set beats clear) and saturating hit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            match_pulse_r <= 1'b0;
            wrap_pulse_r  <= 1'b0;
            irq_r         <= 1'b0;
            hits_r        <= 8'h00;
        end else begin
            match_pulse_r <= match_s;
            wrap_pulse_r  <= wrap_s;
            if (match_s) begin
                irq_r <= 1'b1;
            end else if (irq_clr) begin
                irq_r <= 1'b0;
            end
            if (match_s && (hits_r != 8'hFF)) begin
                hits_r <= hits_r + 8'd1;
            end
        end
    end

`ifdef COUNT_MONITOR_JUMP_DET_EN
    logic jump_s;
    logic jump_pulse_r;

    function automatic logic is_jump(input logic [7:0] prev_v, input logic [7:0] cur_v);
        return (cur_v != prev_v) && (cur_v != (prev_v + 8'd1));
    endfunction

    // Jump decision: neither a hold nor a modulo-256 increment
    always_comb begin
        if (prev_valid_r) begin
            jump_s = is_jump(prev_r, count_in);
        end else begin
            jump_s = 1'b0;
        end
    end

    // Registered jump pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            jump_pulse_r <= 1'b0;
        end else begin
            jump_pulse_r <= jump_s;
        end
    end

    assign jump_pulse = jump_pulse_r;
`else
    assign jump_pulse = 1'b0;
`endif

    assign match_pulse = match_pulse_r;
    assign wrap_pulse  = wrap_pulse_r;
    assign irq         = irq_r;
    assign hits        = hits_r;
    assign state       = state_r;

endmodule

// File: tb/tb_count_monitor.sv
// Directed self-checking bench for count_monitor with HOLD_CYCLES=4.
module tb_count_monitor;

    logic       clk_s = 1'b0;
    logic       reset_s;
    logic [7:0] count_in_s;
    logic       cfg_wr_s;
    logic [7:0] cfg_data_s;
    logic       irq_clr_s;
    logic       match_pulse_s;
    logic       wrap_pulse_s;
    logic       jump_pulse_s;
    logic       irq_s;
    logic [7:0] hits_s;
    logic [1:0] state_s;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic seen_s;

`ifdef COUNT_MONITOR_JUMP_DET_EN
    localparam logic [7:0] JUMP_EXP = 8'd1;
`else
    localparam logic [7:0] JUMP_EXP = 8'd0;
`endif

    count_monitor #(.HOLD_CYCLES(4)) dut (
        .clk        (clk_s),
        .reset      (reset_s),
        .count_in   (count_in_s),
        .cfg_wr     (cfg_wr_s),
        .cfg_data   (cfg_data_s),
        .irq_clr    (irq_clr_s),
        .match_pulse(match_pulse_s),
        .wrap_pulse (wrap_pulse_s),
        .jump_pulse (jump_pulse_s),
        .irq        (irq_s),
        .hits       (hits_s),
        .state      (state_s)
    );

    always #5 clk_s = ~clk_s;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one sample, then look at the registered result just after the edge
    task automatic cyc(input logic [7:0] cnt, input logic wr, input logic [7:0] data, input logic clr);
        count_in_s = cnt;
        cfg_wr_s   = wr;
        cfg_data_s = data;
        irq_clr_s  = clr;
        @(posedge clk_s);
        #1;
    endtask

    initial begin
        reset_s    = 1'b1;
        count_in_s = 8'h00;
        cfg_wr_s   = 1'b0;
        cfg_data_s = 8'h00;
        irq_clr_s  = 1'b0;
        cyc(8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("rst_state", {6'd0, state_s}, 8'd0);
        check_eq("rst_hits", hits_s, 8'h00);
        check_eq("rst_irq", {7'd0, irq_s}, 8'd0);
        check_eq("rst_pulses", {5'd0, match_pulse_s, wrap_pulse_s, jump_pulse_s}, 8'd0);
        reset_s = 1'b0;

        // Program cmp=5 from IDLE, then count up through the match
        cyc(8'h00, 1'b1, 8'h05, 1'b0);
        check_eq("armed", {6'd0, state_s}, 8'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc(8'(i), 1'b0, 8'h00, 1'b0);
            check_eq("pre_match", {7'd0, match_pulse_s}, 8'd0);
        end
        cyc(8'h05, 1'b0, 8'h00, 1'b0);
        check_eq("match1", {7'd0, match_pulse_s}, 8'd1);
        check_eq("match1_state", {6'd0, state_s}, 8'd2);
        check_eq("match1_irq", {7'd0, irq_s}, 8'd1);
        check_eq("match1_hits", hits_s, 8'd1);
        for (int i = 6; i <= 9; i++) begin
            cyc(8'(i), 1'b0, 8'h00, 1'b0);
            check_eq("hold_pulse", {7'd0, match_pulse_s}, 8'd0);
            check_eq("hold_state", {6'd0, state_s}, (i == 9) ? 8'd1 : 8'd2);
        end

        // Count held at cmp for 10 samples: matches accepted at sample 0 and 5
        for (int i = 0; i < 10; i++) begin
            cyc(8'h05, 1'b0, 8'h00, 1'b0);
            check_eq("held_match", {7'd0, match_pulse_s}, (i == 0 || i == 5) ? 8'd1 : 8'd0);
        end
        check_eq("held_hits", hits_s, 8'd3);
        check_eq("held_state", {6'd0, state_s}, 8'd1);

        // Clear coincident with a match loses; clear alone wins
        cyc(8'h05, 1'b0, 8'h00, 1'b1);
        check_eq("clr_vs_set_irq", {7'd0, irq_s}, 8'd1);
        check_eq("clr_vs_set_hits", hits_s, 8'd4);
        cyc(8'h06, 1'b0, 8'h00, 1'b1);
        check_eq("clr_alone_irq", {7'd0, irq_s}, 8'd0);
        for (int i = 7; i <= 9; i++) begin
            cyc(8'(i), 1'b0, 8'h00, 1'b0);
        end
        check_eq("rearm", {6'd0, state_s}, 8'd1);

        // cfg_wr together with a match: old cmp is used; new cmp applies afterwards
        cyc(8'h05, 1'b1, 8'h20, 1'b0);
        check_eq("old_cmp_match", {7'd0, match_pulse_s}, 8'd1);
        check_eq("old_cmp_hits", hits_s, 8'd5);
        for (int i = 6; i <= 9; i++) begin
            cyc(8'(i), 1'b0, 8'h00, 1'b0);
        end
        cyc(8'h20, 1'b0, 8'h00, 1'b0);
        check_eq("new_cmp_match", {7'd0, match_pulse_s}, 8'd1);
        cyc(8'h21, 1'b1, 8'h30, 1'b0);
        check_eq("cfg_in_hold_state", {6'd0, state_s}, 8'd2);
        for (int i = 8'h22; i <= 8'h24; i++) begin
            cyc(8'(i), 1'b0, 8'h00, 1'b0);
        end
        check_eq("rearm2", {6'd0, state_s}, 8'd1);
        cyc(8'h30, 1'b0, 8'h00, 1'b0);
        check_eq("cmp30_match", {7'd0, match_pulse_s}, 8'd1);
        check_eq("cmp30_hits", hits_s, 8'd7);

        // Wrap sequence FE, FF, 00, 01
        cyc(8'hFE, 1'b0, 8'h00, 1'b0);
        cyc(8'hFF, 1'b0, 8'h00, 1'b0);
        check_eq("ff_wrap", {7'd0, wrap_pulse_s}, 8'd0);
        check_eq("ff_jump", {7'd0, jump_pulse_s}, 8'd0);
        cyc(8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("wrap", {7'd0, wrap_pulse_s}, 8'd1);
        check_eq("wrap_no_jump", {7'd0, jump_pulse_s}, 8'd0);
        cyc(8'h01, 1'b0, 8'h00, 1'b0);
        check_eq("post_wrap", {7'd0, wrap_pulse_s}, 8'd0);
        check_eq("post_wrap_jump", {7'd0, jump_pulse_s}, 8'd0);

        // Jump 10 -> 40, then increment and hold are not jumps
        cyc(8'h10, 1'b0, 8'h00, 1'b0);
        cyc(8'h40, 1'b0, 8'h00, 1'b0);
        check_eq("jump", {7'd0, jump_pulse_s}, JUMP_EXP);
        cyc(8'h41, 1'b0, 8'h00, 1'b0);
        check_eq("incr_no_jump", {7'd0, jump_pulse_s}, 8'd0);
        cyc(8'h41, 1'b0, 8'h00, 1'b0);
        check_eq("hold_no_jump", {7'd0, jump_pulse_s}, 8'd0);
        check_eq("no_wrap", {7'd0, wrap_pulse_s}, 8'd0);

        // Drive hits into saturation with a held matching count
        cyc(8'h41, 1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 1300; i++) begin
            cyc(8'h77, 1'b0, 8'h00, 1'b0);
        end
        check_eq("hits_sat", hits_s, 8'hFF);
        seen_s = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!seen_s) begin
                cyc(8'h77, 1'b0, 8'h00, 1'b0);
                seen_s = match_pulse_s;
            end
        end
        check_eq("sat_match_seen", {7'd0, seen_s}, 8'd1);
        check_eq("hits_no_roll", hits_s, 8'hFF);
        cyc(8'h77, 1'b0, 8'h00, 1'b0);
        cyc(8'h77, 1'b0, 8'h00, 1'b0);
        check_eq("mid_hold", {6'd0, state_s}, 8'd2);

        // Reset mid-hold beats cfg_wr, irq_clr and a matching sample
        reset_s = 1'b1;
        cyc(8'hFF, 1'b1, 8'h99, 1'b1);
        reset_s = 1'b0;
        check_eq("rst2_state", {6'd0, state_s}, 8'd0);
        check_eq("rst2_hits", hits_s, 8'h00);
        check_eq("rst2_irq", {7'd0, irq_s}, 8'd0);
        check_eq("rst2_pulses", {5'd0, match_pulse_s, wrap_pulse_s, jump_pulse_s}, 8'd0);
        cyc(8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("post_rst_pulses", {5'd0, match_pulse_s, wrap_pulse_s, jump_pulse_s}, 8'd0);
        check_eq("post_rst_idle", {6'd0, state_s}, 8'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
